// File: rtl/xreg_operand_reader.sv
// Operand reader: resolves two source registers (with write-port bypass),
// stalls on scoreboard hazards, and holds the result in a one-entry output register.
module xreg_operand_reader #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int IDX_W  = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [IDX_W-1:0]            req_rs1,
    input  logic [IDX_W-1:0]            req_rs2,
    input  logic [IDX_W-1:0]            req_rd,
    input  logic                        req_rd_pend,
    input  logic [NREG-1:0][DATA_W-1:0] x,
    input  logic                        wreq,
    input  logic [IDX_W-1:0]            windex,
    input  logic [DATA_W-1:0]           wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_op1,
    output logic [DATA_W-1:0]           rsp_op2,
    output logic [IDX_W-1:0]            rsp_rd,
    output logic [NREG-1:0]             pend
);

    logic [DATA_W-1:0] op1_p0;
    logic [DATA_W-1:0] op2_p0;
    logic              haz1_p0;
    logic              haz2_p0;
    logic              accept_p0;
    logic              complete_p0;
    logic              vld_p1;
    logic [DATA_W-1:0] op1_p1;
    logic [DATA_W-1:0] op2_p1;
    logic [IDX_W-1:0]  rd_p1;
    logic [NREG-1:0]   pend_q;
    logic [NREG-1:0]   pend_next;

    function automatic logic [DATA_W-1:0] resolve(
        input logic [IDX_W-1:0]            idx,
        input logic [NREG-1:0][DATA_W-1:0] regs,
        input logic                        wr_en,
        input logic [IDX_W-1:0]            wr_idx,
        input logic [DATA_W-1:0]           wr_data
    );
        if (idx == '0)
            return '0;
        else if (wr_en && wr_idx == idx)
            return wr_data;
        else
            return regs[idx];
    endfunction

    // A pending source is not a hazard if its write lands this very cycle.
    function automatic logic hazard(
        input logic [IDX_W-1:0] idx,
        input logic [NREG-1:0]  pmask,
        input logic             wr_en,
        input logic [IDX_W-1:0] wr_idx
    );
        return (idx != '0) && pmask[idx] && !(wr_en && wr_idx == idx);
    endfunction

    // Stage p0: combinational operand resolution and handshake.
    always_comb begin
        op1_p0      = resolve(req_rs1, x, wreq, windex, wdata);
        op2_p0      = resolve(req_rs2, x, wreq, windex, wdata);
        haz1_p0     = hazard(req_rs1, pend_q, wreq, windex);
        haz2_p0     = hazard(req_rs2, pend_q, wreq, windex);
        req_ready   = (!vld_p1 || rsp_ready) && !haz1_p0 && !haz2_p0;
        accept_p0   = req_valid && req_ready;
        complete_p0 = vld_p1 && rsp_ready;
    end

    // Clear on write first so a same-edge set of the same index wins.
    always_comb begin
        pend_next = pend_q;
        if (wreq)
            pend_next[windex] = 1'b0;
        if (accept_p0 && req_rd_pend && req_rd != '0)
            pend_next[req_rd] = 1'b1;
        pend_next[0] = 1'b0;
    end

    // Stage p1: output register and scoreboard.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
            op1_p1 <= '0;
            op2_p1 <= '0;
            rd_p1  <= '0;
            pend_q <= '0;
        end else begin
            pend_q <= pend_next;
            if (accept_p0) begin
                vld_p1 <= 1'b1;
                op1_p1 <= op1_p0;
                op2_p1 <= op2_p0;
                rd_p1  <= req_rd;
            end else if (complete_p0) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_op1   = op1_p1;
    assign rsp_op2   = op2_p1;
    assign rsp_rd    = rd_p1;
    assign pend      = pend_q;

endmodule

// File: tb/tb_xreg_operand_reader.sv
// Directed bench for xreg_operand_reader: read, bypass, hazard, backpressure,
// zero register, set/clear collision, and asynchronous reset.
module tb_xreg_operand_reader;

    logic             clk;
    logic             rstn;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_rs1;
    logic [3:0]       req_rs2;
    logic [3:0]       req_rd;
    logic             req_rd_pend;
    logic [15:0][31:0] x;
    logic             wreq;
    logic [3:0]       windex;
    logic [31:0]      wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_op1;
    logic [31:0]      rsp_op2;
    logic [3:0]       rsp_rd;
    logic [15:0]      pend;

    int checks;
    int errors;

    xreg_operand_reader dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_rd      (req_rd),
        .req_rd_pend (req_rd_pend),
        .x           (x),
        .wreq        (wreq),
        .windex      (windex),
        .wdata       (wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_op1     (rsp_op1),
        .rsp_op2     (rsp_op2),
        .rsp_rd      (rsp_rd),
        .pend        (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [3:0] rs1, input logic [3:0] rs2,
                           input logic [3:0] rd, input logic rdp);
        req_valid   = 1'b1;
        req_rs1     = rs1;
        req_rs2     = rs2;
        req_rd      = rd;
        req_rd_pend = rdp;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rstn        = 1'b0;
        req_valid   = 1'b0;
        req_rs1     = '0;
        req_rs2     = '0;
        req_rd      = '0;
        req_rd_pend = 1'b0;
        x           = '0;
        wreq        = 1'b0;
        windex      = '0;
        wdata       = '0;
        rsp_ready   = 1'b1;
        #1;
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_pend",      {16'b0, pend},      32'h0);
        check("rst_op1",       rsp_op1,            32'h0);
        check("rst_op2",       rsp_op2,            32'h0);
        check("rst_rd",        {28'b0, rsp_rd},    32'h0);
        tick();
        rstn = 1'b1;

        // basic read
        x[3] = 32'h11;
        x[5] = 32'h22;
        request(4'd3, 4'd5, 4'd2, 1'b0);
        #1;
        check("basic_ready", {31'b0, req_ready}, 32'h1);
        tick();
        check("basic_valid", {31'b0, rsp_valid}, 32'h1);
        check("basic_op1",   rsp_op1,            32'h11);
        check("basic_op2",   rsp_op2,            32'h22);
        check("basic_rd",    {28'b0, rsp_rd},    32'h2);

        // bypass, also a write to a non-pending index
        request(4'd3, 4'd0, 4'd6, 1'b0);
        wreq = 1'b1; windex = 4'd3; wdata = 32'hAB;
        tick();
        check("bypass_op1",   rsp_op1,            32'hAB);
        check("bypass_op2",   rsp_op2,            32'h0);
        check("bypass_valid", {31'b0, rsp_valid}, 32'h1);
        check("bypass_pend",  {16'b0, pend},      32'h0);
        wreq = 1'b0;

        // hazard on rd=7
        request(4'd1, 4'd0, 4'd7, 1'b1);
        tick();
        check("haz_pend_set", {16'b0, pend}, 32'h0080);
        request(4'd7, 4'd0, 4'd0, 1'b0);
        #1;
        check("haz_stall0", {31'b0, req_ready}, 32'h0);
        tick();
        check("haz_drained", {31'b0, rsp_valid}, 32'h0);
        check("haz_stall1",  {31'b0, req_ready}, 32'h0);
        check("haz_pend_hold", {16'b0, pend},    32'h0080);
        wreq = 1'b1; windex = 4'd7; wdata = 32'h5;
        #1;
        check("haz_release", {31'b0, req_ready}, 32'h1);
        tick();
        check("haz_op1",   rsp_op1,            32'h5);
        check("haz_pend0", {16'b0, pend},      32'h0);
        check("haz_valid", {31'b0, rsp_valid}, 32'h1);
        wreq = 1'b0;

        // rs1 == rs2, pending and written this cycle
        request(4'd0, 4'd0, 4'd9, 1'b1);
        tick();
        check("same_pend_set", {16'b0, pend}, 32'h0200);
        request(4'd9, 4'd9, 4'd0, 1'b0);
        wreq = 1'b1; windex = 4'd9; wdata = 32'h77;
        #1;
        check("same_ready", {31'b0, req_ready}, 32'h1);
        tick();
        check("same_op1", rsp_op1, 32'h77);
        check("same_op2", rsp_op2, 32'h77);
        check("same_pend0", {16'b0, pend}, 32'h0);
        wreq = 1'b0;

        // backpressure
        x[3] = 32'h11;
        request(4'd3, 4'd5, 4'd1, 1'b0);
        tick();
        check("bp_op1_load", rsp_op1, 32'h11);
        request(4'd5, 4'd0, 4'd2, 1'b0);
        rsp_ready = 1'b0;
        x[3] = 32'h99;
        wreq = 1'b1; windex = 4'd3; wdata = 32'h99;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", {31'b0, req_ready}, 32'h0);
            tick();
            check("bp_op1",   rsp_op1,            32'h11);
            check("bp_rd",    {28'b0, rsp_rd},    32'h1);
            check("bp_valid", {31'b0, rsp_valid}, 32'h1);
        end
        wreq = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("bp_drain", {31'b0, rsp_valid}, 32'h0);

        // zero register and rd=0 pending
        request(4'd0, 4'd5, 4'd0, 1'b1);
        tick();
        check("zero_op1", rsp_op1, 32'h0);
        check("zero_op2", rsp_op2, 32'h22);
        check("zero_pend", {16'b0, pend}, 32'h0);

        // same-edge set/clear of index 4
        request(4'd0, 4'd0, 4'd4, 1'b1);
        wreq = 1'b1; windex = 4'd4; wdata = 32'h44;
        tick();
        check("setclr_pend", {16'b0, pend}, 32'h0010);
        wreq = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        check("pre_rst_valid", {31'b0, rsp_valid}, 32'h1);

        // asynchronous reset mid-operation
        #2;
        rstn = 1'b0;
        #1;
        check("arst_valid", {31'b0, rsp_valid}, 32'h0);
        check("arst_pend",  {16'b0, pend},      32'h0);
        check("arst_op1",   rsp_op1,            32'h0);
        #2;
        rstn = 1'b1;
        rsp_ready = 1'b1;
        request(4'd4, 4'd0, 4'd3, 1'b0);
        #1;
        check("arst_ready", {31'b0, req_ready}, 32'h1);
        tick();
        check("arst_resume_valid", {31'b0, rsp_valid}, 32'h1);
        check("arst_resume_op1",   rsp_op1,            32'h0);
        req_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xreg_operand_reader.md
XREG_OPERAND_READER -- requirements
Module: xreg_operand_reader

Interface
REQ-001 SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have the port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have the port req_valid, input, 1 bit: an operand-read request is present.
REQ-004 SHALL have the port req_ready, output, 1 bit: the block accepts the request this cycle.
REQ-005 SHALL have the ports req_rs1 and req_rs2, inputs, 4 bits each: the source register indices.
REQ-006 SHALL have the port req_rd, input, 4 bits: the destination index carried with the request.
REQ-007 SHALL have the port req_rd_pend, input, 1 bit: this request will write req_rd later, so mark req_rd pending.
REQ-008 SHALL have the port x, input, 16 x 32 bits: the current register-file contents; x[0] reads as 0.
REQ-009 SHALL have the ports wreq (1 bit), windex (4 bits) and wdata (32 bits), inputs: a snoop of the register-file write port, in the same cycle as the write.
REQ-010 SHALL have the port rsp_valid, output, 1 bit: the operand response is valid.
REQ-011 SHALL have the port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-012 SHALL have the ports rsp_op1 and rsp_op2, outputs, 32 bits each: the operand values.
REQ-013 SHALL have the port rsp_rd, output, 4 bits: the captured req_rd.
REQ-014 SHALL have the port pend, output, 16 bits: the scoreboard; bit i set means register i has a write outstanding.

Function
REQ-015 SHALL resolve each operand combinationally:
- index 0: the operand is 0.
- else, if wreq && windex == index: the operand is wdata (bypass).
- else: the operand is x[index].
REQ-016 SHALL define a hazard for source rsN when rsN != 0, pend[rsN] = 1, and NOT (wreq && windex == rsN).
REQ-017 SHALL drive req_ready = (!rsp_valid || rsp_ready) && !hazard(rs1) && !hazard(rs2); req_ready does not depend on req_valid.
REQ-018 SHALL accept a request when req_valid && req_ready; on that edge it captures both resolved operands and req_rd into the output register and sets rsp_valid = 1.
REQ-019 SHALL complete a response when rsp_valid && rsp_ready; with no new acceptance on that edge, rsp_valid becomes 0.
REQ-020 SHALL, when a response completes and a request is accepted on the same edge, load the new values and keep rsp_valid = 1 (full throughput, one per cycle).
REQ-021 SHALL hold rsp_op1, rsp_op2 and rsp_rd stable while rsp_valid && !rsp_ready, ignoring later writes to the sourced registers.
REQ-022 SHALL set pend[req_rd] on acceptance when req_rd_pend = 1 and req_rd != 0.
REQ-023 SHALL clear pend[windex] when wreq = 1.
REQ-024 SHALL, when set and clear hit the same index on the same edge, let the set win.
REQ-025 SHALL keep pend[0] = 0 permanently.
REQ-026 SHALL ignore a write with wreq = 1 to a non-pending index for scoreboard purposes; that bit stays 0.
REQ-027 SHALL give req_valid no effect on state while req_ready = 0; the requester holds the request.
REQ-028 SHALL apply no stall when rs1 == rs2 and the register is pending and written this cycle; both operands take wdata.

Reset
REQ-029 SHALL, while rstn = 0 and independent of clk: rsp_valid = 0, pend = 16'h0000, rsp_op1 = 0, rsp_op2 = 0, rsp_rd = 0.
REQ-030 SHALL discard any in-flight response and all pending marks when reset is asserted mid-operation; after release, req_ready = 1 on the first cycle.
REQ-031 SHALL resume normal operation on the first rising clk edge after rstn deasserts.

Verification
REQ-032 SHALL cover basic read: x[3]=32'h11, x[5]=32'h22, request rs1=3, rs2=5, rsp_ready=1 -> next cycle rsp_valid=1, op1=32'h11, op2=32'h22.
REQ-033 SHALL cover bypass: x[3]=32'h11, wreq=1, windex=3, wdata=32'hAB in the request cycle -> op1=32'hAB.
REQ-034 SHALL cover hazard: accept rd=7 with rd_pend=1 -> pend=16'h0080; a following rs1=7 holds req_ready=0 until wreq, windex=7, wdata=32'h5 -> accepted that cycle with op1=32'h5 and pend=16'h0000.
REQ-035 SHALL cover backpressure: rsp_ready=0 for 3 cycles with response op1=32'h11 while x[3] is written to 32'h99 -> op1 stays 32'h11 and req_ready=0 throughout.
REQ-036 SHALL cover the zero register and simultaneous set/clear: rs1=0 -> op1=0; rd=0 with rd_pend=1 -> pend unchanged; accept rd=4 with rd_pend=1 while wreq, windex=4 -> pend[4]=1.
REQ-037 SHALL cover reset mid-operation: rsp_valid=1 and pend=16'h0010, assert rstn=0 asynchronously -> rsp_valid=0 and pend=0 immediately.
